hazard_ctrl: RTL and testbench

//  Hazard detection/sequencing unit for the 5-stage pipeline. Watches ID operands vs EX/MEM destinations.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_regmatch.sv | 25 ++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// FSM encoding, default register-number width and bubble-count codes.
package hazard_pkg;

    localparam int unsigned REGW_DEF = 5;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StBub2   = 2'd1,
        StFreeze = 2'd2
    } hz_state_e;

    // Number of bubbles a detected hazard asks for in the current cycle.
    localparam logic [1:0] BUB_NONE = 2'd0;
    localparam logic [1:0] BUB_ONE  = 2'd1;
    localparam logic [1:0] BUB_TWO  = 2'd2;

endpackage

// File: rtl/hazard_regmatch.sv
// Compares the ID instruction's source registers against one stage's destination.
// Register 0 is hard-wired and never produces a hazard.
module hazard_regmatch #(
    parameter int unsigned REGW = hazard_pkg::REGW_DEF
) (
    input  logic [REGW-1:0] idrs,
    input  logic [REGW-1:0] idrt,
    input  logic            idusers,
    input  logic            iduserts,
    input  logic [REGW-1:0] dst,
    output logic            hit
);

    logic dst_nz;
    logic mrs;
    logic mrt;

    always_comb begin
        dst_nz = (dst != '0);
        mrs    = idusers  && (idrs == dst) && dst_nz;
        mrt    = iduserts && (idrt == dst) && dst_nz;
        hit    = mrs || mrt;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection/sequencing for the 5-stage pipeline: bubbles, flushes and memory freezes.
// Optional perf counters (stallcnt/flushcnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REGW = REGW_DEF
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNTW = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] idrs,
    input  logic [REGW-1:0] idrt,
    input  logic            idusers,
    input  logic            iduserts,
    input  logic            idbranch,
    input  logic            exmemrd,
    input  logic            exregwr,
    input  logic [REGW-1:0] exwreg,
    input  logic            memmemrd,
    input  logic [REGW-1:0] memwreg,
    input  logic            brtaken,
    input  logic            idjump,
    input  logic            memwait,
    output logic            pcwrite,
    output logic            ifidwrite,
    output logic            ctrlsig,
    output logic            ifidflush,
    output logic            stalling
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNTW-1:0] stallcnt,
    output logic [CNTW-1:0] flushcnt
`endif
);

    hz_state_e state_q, state_d;

    logic       hit_ex;
    logic       hit_mem;
    logic       loaduse;
    logic       bralu;
    logic       brld2;
    logic       brld1;
    logic [1:0] nbub;

    hazard_regmatch #(
        .REGW (REGW)
    ) u_match_ex (
        .idrs     (idrs),
        .idrt     (idrt),
        .idusers  (idusers),
        .iduserts (iduserts),
        .dst      (exwreg),
        .hit      (hit_ex)
    );

    hazard_regmatch #(
        .REGW (REGW)
    ) u_match_mem (
        .idrs     (idrs),
        .idrt     (idrt),
        .idusers  (idusers),
        .iduserts (iduserts),
        .dst      (memwreg),
        .hit      (hit_mem)
    );

    // Branches compare in ID, so an ALU result still in EX cannot be forwarded in time.
    always_comb begin
        loaduse = exmemrd && hit_ex;
        bralu   = idbranch && exregwr && !exmemrd && hit_ex;
        brld2   = idbranch && exmemrd && hit_ex;
        brld1   = idbranch && memmemrd && hit_mem;
        if (brld2) begin
            nbub = BUB_TWO;
        end else if (loaduse || bralu || brld1) begin
            nbub = BUB_ONE;
        end else begin
            nbub = BUB_NONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcwrite   = 1'b1;
        ifidwrite = 1'b1;
        ctrlsig   = 1'b0;
        ifidflush = 1'b0;
        stalling  = 1'b0;

        if (rst) begin
            state_d   = StRun;
            pcwrite   = 1'b0;
            ifidwrite = 1'b0;
            ctrlsig   = 1'b1;
            ifidflush = 1'b1;
        end else if (memwait || (state_q == StFreeze)) begin
            // ID/EX is held by the memory stall logic, so no bubble is injected here.
            state_d   = memwait ? StFreeze : StRun;
            pcwrite   = 1'b0;
            ifidwrite = 1'b0;
            stalling  = 1'b1;
        end else begin
            case (state_q)
                StBub2: begin
                    state_d   = StRun;
                    pcwrite   = 1'b0;
                    ifidwrite = 1'b0;
                    ctrlsig   = 1'b1;
                    stalling  = 1'b1;
                end
                StRun: begin
                    if (nbub != BUB_NONE) begin
                        state_d   = (nbub == BUB_TWO) ? StBub2 : StRun;
                        pcwrite   = 1'b0;
                        ifidwrite = 1'b0;
                        ctrlsig   = 1'b1;
                        stalling  = 1'b1;
                    end else begin
                        ifidflush = brtaken || idjump;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNTW-1:0] stallcnt_q;
    logic [CNTW-1:0] flushcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallcnt_q <= '0;
            flushcnt_q <= '0;
        end else begin
            if (ctrlsig && (stallcnt_q != '1)) begin
                stallcnt_q <= stallcnt_q + 1'b1;
            end
            if (ifidflush && (flushcnt_q != '1)) begin
                flushcnt_q <= flushcnt_q + 1'b1;
            end
        end
    end

    assign stallcnt = stallcnt_q;
    assign flushcnt = flushcnt_q;
`else
    // No counter state in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 32;

    // {pcwrite, ifidwrite, ctrlsig, ifidflush, stalling}
    localparam logic [4:0] V_RUN   = 5'b11000;
    localparam logic [4:0] V_FLUSH = 5'b11010;
    localparam logic [4:0] V_BUB   = 5'b00101;
    localparam logic [4:0] V_FRZ   = 5'b00001;
    localparam logic [4:0] V_RST   = 5'b00110;

    logic            clk;
    logic            rst;
    logic [REGW-1:0] idrs;
    logic [REGW-1:0] idrt;
    logic            idusers;
    logic            iduserts;
    logic            idbranch;
    logic            exmemrd;
    logic            exregwr;
    logic [REGW-1:0] exwreg;
    logic            memmemrd;
    logic [REGW-1:0] memwreg;
    logic            brtaken;
    logic            idjump;
    logic            memwait;
    logic            pcwrite;
    logic            ifidwrite;
    logic            ctrlsig;
    logic            ifidflush;
    logic            stalling;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNTW-1:0] stallcnt;
    logic [CNTW-1:0] flushcnt;
    int unsigned     exp_stall;
    int unsigned     exp_flush;
`endif

    int unsigned total;
    int unsigned bad;

    hazard_ctrl #(
        .REGW (REGW)
`ifdef HAZARD_PERF_CNT_EN
      , .CNTW (CNTW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .idrs      (idrs),
        .idrt      (idrt),
        .idusers   (idusers),
        .iduserts  (iduserts),
        .idbranch  (idbranch),
        .exmemrd   (exmemrd),
        .exregwr   (exregwr),
        .exwreg    (exwreg),
        .memmemrd  (memmemrd),
        .memwreg   (memwreg),
        .brtaken   (brtaken),
        .idjump    (idjump),
        .memwait   (memwait),
        .pcwrite   (pcwrite),
        .ifidwrite (ifidwrite),
        .ctrlsig   (ctrlsig),
        .ifidflush (ifidflush),
        .stalling  (stalling)
`ifdef HAZARD_PERF_CNT_EN
      , .stallcnt  (stallcnt),
        .flushcnt  (flushcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        rst      = 1'b0;
        idrs     = '0;
        idrt     = '0;
        idusers  = 1'b0;
        iduserts = 1'b0;
        idbranch = 1'b0;
        exmemrd  = 1'b0;
        exregwr  = 1'b0;
        exwreg   = '0;
        memmemrd = 1'b0;
        memwreg  = '0;
        brtaken  = 1'b0;
        idjump   = 1'b0;
        memwait  = 1'b0;
    endtask

    // Called just after the negedge stimulus; samples well before the next rising edge.
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        #1;
        got = {pcwrite, ifidwrite, ctrlsig, ifidflush, stalling};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s outputs got=%b exp=%b", tag, got, exp);
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        assert (stallcnt === CNTW'(exp_stall)) else begin
            bad++;
            $error("FAIL %s stallcnt got=%0d exp=%0d", tag, stallcnt, exp_stall);
        end
        total++;
        assert (flushcnt === CNTW'(exp_flush)) else begin
            bad++;
            $error("FAIL %s flushcnt got=%0d exp=%0d", tag, flushcnt, exp_flush);
        end
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            exp_stall += exp[2] ? 1 : 0;
            exp_flush += exp[1] ? 1 : 0;
        end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 0;
        exp_flush = 0;
`endif
        clr();
        rst = 1'b1;

        @(negedge clk); clr(); rst = 1'b1;                 chk("reset_a", V_RST);
        @(negedge clk); clr(); rst = 1'b1;                 chk("reset_b", V_RST);
        @(negedge clk); clr();                             chk("run_idle", V_RUN);

        // load-use: lw r2 in EX, add reads rs=2
        @(negedge clk); clr(); exmemrd = 1'b1; exwreg = 5'd2; idusers = 1'b1; idrs = 5'd2;
        chk("loaduse", V_BUB);
        @(negedge clk); clr();                             chk("loaduse_after", V_RUN);
        // rs matches but instruction does not read it
        @(negedge clk); clr(); exmemrd = 1'b1; exwreg = 5'd2; idrs = 5'd2;
        chk("loaduse_unused", V_RUN);
        // ALU producer with non-branch consumer is forwarded
        @(negedge clk); clr(); exregwr = 1'b1; exwreg = 5'd7; idusers = 1'b1; idrs = 5'd7;
        chk("alu_fwd", V_RUN);

        // beq rs=3 with lw r3 in EX: two bubbles even after inputs change
        @(negedge clk); clr(); idbranch = 1'b1; idusers = 1'b1; idrs = 5'd3;
        exmemrd = 1'b1; exwreg = 5'd3;
        chk("brld2_1", V_BUB);
        @(negedge clk); clr();                             chk("brld2_2", V_BUB);
        @(negedge clk); clr();                             chk("brld2_done", V_RUN);

        // beq rt=4 with add r4 in EX
        @(negedge clk); clr(); idbranch = 1'b1; iduserts = 1'b1; idrt = 5'd4;
        exregwr = 1'b1; exwreg = 5'd4;
        chk("bralu", V_BUB);
        @(negedge clk); clr(); idbranch = 1'b1; iduserts = 1'b1; idrt = 5'd0;
        exregwr = 1'b1; exwreg = 5'd0;
        chk("bralu_r0", V_RUN);
        // beq rs=5 with lw r5 in MEM
        @(negedge clk); clr(); idbranch = 1'b1; idusers = 1'b1; idrs = 5'd5;
        memmemrd = 1'b1; memwreg = 5'd5;
        chk("brld1", V_BUB);

        // flushes, and bubble beats flush
        @(negedge clk); clr(); brtaken = 1'b1;             chk("flush_br", V_FLUSH);
        @(negedge clk); clr(); idjump = 1'b1;              chk("flush_j", V_FLUSH);
        @(negedge clk); clr(); brtaken = 1'b1; exmemrd = 1'b1; exwreg = 5'd9;
        idusers = 1'b1; idrs = 5'd9;
        chk("flush_vs_bub", V_BUB);

        // memwait during BUB2: freeze, bubble not re-issued
        @(negedge clk); clr(); idbranch = 1'b1; iduserts = 1'b1; idrt = 5'd6;
        exmemrd = 1'b1; exwreg = 5'd6;
        chk("frz_pre", V_BUB);
        @(negedge clk); clr(); memwait = 1'b1;             chk("frz_bub2", V_FRZ);
        @(negedge clk); clr(); memwait = 1'b1;             chk("frz_1", V_FRZ);
        @(negedge clk); clr(); memwait = 1'b1;             chk("frz_2", V_FRZ);
        @(negedge clk); clr();                             chk("frz_3", V_FRZ);
        @(negedge clk); clr();                             chk("frz_done", V_RUN);
        // memwait beats a load-use bubble
        @(negedge clk); clr(); memwait = 1'b1; exmemrd = 1'b1; exwreg = 5'd1;
        idusers = 1'b1; idrs = 5'd1;
        chk("frz_vs_bub", V_FRZ);
        @(negedge clk); clr(); brtaken = 1'b1;             chk("frz_tail", V_FRZ);
        @(negedge clk); clr();                             chk("frz_tail_run", V_RUN);

        // reset in BUB2 aborts the second bubble
        @(negedge clk); clr(); idbranch = 1'b1; idusers = 1'b1; idrs = 5'd8;
        exmemrd = 1'b1; exwreg = 5'd8;
        chk("rst_pre", V_BUB);
        @(negedge clk); clr(); rst = 1'b1;                 chk("rst_bub2", V_RST);
        @(negedge clk); clr();                             chk("rst_after", V_RUN);
        // reset while frozen
        @(negedge clk); clr(); memwait = 1'b1;             chk("rst_frz_pre", V_FRZ);
        @(negedge clk); clr(); rst = 1'b1;                 chk("rst_frz", V_RST);
        @(negedge clk); clr();                             chk("rst_frz_after", V_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
